// File: rtl/mux2_pkg.sv
`default_nettype none
// ============================================================
// Package : mux2_pkg
// Desc    : Shared constants for the mux2 steering element.
// Rev     : 1.0  initial release
// ============================================================
package mux2_pkg;

    localparam int c_width_min = 1;
    localparam int c_width_max = 64;

endpackage : mux2_pkg
`default_nettype wire

// File: rtl/mux2_cell.sv
`default_nettype none
// ============================================================
// Module : mux2_cell
// Desc   : Purely combinational WIDTH-bit two-input selector.
// Rev    : 1.0  initial release
// ============================================================
module mux2_cell #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Conditional operator merges a/b bitwise when sel is X/Z: agreeing bits pass, others go X.
    assign y = sel ? b : a;

endmodule : mux2_cell
`default_nettype wire

// File: rtl/mux2.sv
`default_nettype none
// ============================================================
// Module : mux2
// Desc   : Two-input selector with combinational output and an
//          enabled, asynchronously reset registered copy.
// Rev    : 1.0  initial release
// ============================================================
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
);

    import mux2_pkg::*;

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_q;

    generate
        if (WIDTH < c_width_min || WIDTH > c_width_max) begin : g_width_check
            $error("mux2: WIDTH %0d outside legal range", WIDTH);
        end
    endgenerate

    mux2_cell #(
        .WIDTH (WIDTH)
    ) u_cell (
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (w_out)
    );

    // Registering the cell output keeps out_q identical to what out showed at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q <= '0;
            r_sel_q <= 1'b0;
        end else if (en) begin
            r_out_q <= w_out;
            r_sel_q <= sel;
        end
    end

    assign out   = w_out;
    assign out_q = r_out_q;
    assign sel_q = r_sel_q;

endmodule : mux2
`default_nettype wire

// File: tb/tb_mux2.sv
`default_nettype none
// ============================================================
// Module : tb_mux2
// Desc   : Self-checking bench for mux2 at WIDTH 1, 8 and 16.
// Rev    : 1.0  initial release
// ============================================================
module tb_mux2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a1 = 1'b0, b1 = 1'b0, sel1 = 1'b0, en1 = 1'b0;
    logic        out1, outq1, selq1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        sel8 = 1'b0, en8 = 1'b0;
    logic [7:0]  out8, outq8;
    logic        selq8;
    logic [15:0] a16 = '0, b16 = '0;
    logic        sel16 = 1'b0, en16 = 1'b0;
    logic [15:0] out16, outq16;
    logic        selq16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux2 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1), .en(en1),
        .out(out1), .out_q(outq1), .sel_q(selq1)
    );
    mux2 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel8), .en(en8),
        .out(out8), .out_q(outq8), .sel_q(selq8)
    );
    mux2 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .sel(sel16), .en(en16),
        .out(out16), .out_q(outq16), .sel_q(selq16)
    );

    task automatic test_reset();
        #1;
        total++;
        if (outq8 !== 8'h00) begin
            bad++;
            $display("FAIL reset_outq8: got %h expected %h", outq8, 8'h00);
        end
        total++;
        if (selq8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_selq8: got %b expected %b", selq8, 1'b0);
        end
        total++;
        if (outq16 !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outq16: got %h expected %h", outq16, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [7:0] tt;
        logic [2:0] v;
        tt = 8'hD8;   // bit index {a,b,sel}
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; sel1 = v[0];
            #5;
            total++;
            if (out1 !== tt[i]) begin
                bad++;
                $display("FAIL truth_%0d%0d%0d: got %b expected %b", v[2], v[1], v[0], out1, tt[i]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'hA5; sel8 = 1'b1; en8 = 1'b1;
        #1;
        total++;
        if (out8 !== 8'hA5) begin
            bad++;
            $display("FAIL lat_out: got %h expected %h", out8, 8'hA5);
        end
        @(posedge clk); #1;
        total++;
        if (outq8 !== 8'hA5 || selq8 !== 1'b1) begin
            bad++;
            $display("FAIL lat_outq_sel1: got %h/%b expected %h/%b", outq8, selq8, 8'hA5, 1'b1);
        end
        @(negedge clk);
        sel8 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (outq8 !== 8'h3C || selq8 !== 1'b0) begin
            bad++;
            $display("FAIL lat_outq_sel0: got %h/%b expected %h/%b", outq8, selq8, 8'h3C, 1'b0);
        end
    endtask

    task automatic test_enable_hold();
        logic [7:0] ea;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h00; sel8 = 1'b0; en8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (outq8 !== 8'h5A) begin
            bad++;
            $display("FAIL hold_load: got %h expected %h", outq8, 8'h5A);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 1'($urandom);
            ea = sel8 ? b8 : a8;
            #1;
            total++;
            if (out8 !== ea) begin
                bad++;
                $display("FAIL hold_out_%0d: got %h expected %h", i, out8, ea);
            end
            @(posedge clk); #1;
            total++;
            if (outq8 !== 8'h5A) begin
                bad++;
                $display("FAIL hold_outq_%0d: got %h expected %h", i, outq8, 8'h5A);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; sel8 = 1'b0; en8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (outq8 !== 8'hFF) begin
            bad++;
            $display("FAIL arst_load: got %h expected %h", outq8, 8'hFF);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (outq8 !== 8'h00 || selq8 !== 1'b0) begin
            bad++;
            $display("FAIL arst_clear: got %h/%b expected %h/%b", outq8, selq8, 8'h00, 1'b0);
        end
        total++;
        if (out8 !== 8'hFF) begin
            bad++;
            $display("FAIL arst_out: got %h expected %h", out8, 8'hFF);
        end
        @(posedge clk); #1;
        total++;
        if (outq8 !== 8'h00) begin
            bad++;
            $display("FAIL arst_held: got %h expected %h", outq8, 8'h00);
        end
        #3;
        rst = 1'b0;
        a8 = 8'hC3; b8 = 8'h11; sel8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (outq8 !== 8'h11 || selq8 !== 1'b1) begin
            bad++;
            $display("FAIL arst_release: got %h/%b expected %h/%b", outq8, selq8, 8'h11, 1'b1);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h99; sel8 = 1'b0; en8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sel8 = 1'b1;
        @(posedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (outq8 !== 8'h00 || selq8 !== 1'b0) begin
            bad++;
            $display("FAIL collide: got %h/%b expected %h/%b", outq8, selq8, 8'h00, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        en8 = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] m_q;
        logic        m_sel_q;
        logic [15:0] m_out;
        logic [15:0] smask;
        m_q = '0;
        m_sel_q = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom);
            sel16 = 1'($urandom); en16 = 1'($urandom);
            smask = {16{sel16}};
            m_out = (b16 & smask) | (a16 & ~smask);
            #1;
            total++;
            if (out16 !== m_out) begin
                bad++;
                $display("FAIL rnd_out_%0d: got %h expected %h", i, out16, m_out);
            end
            @(posedge clk);
            if (en16) begin
                m_q = m_out;
                m_sel_q = sel16;
            end
            #1;
            total++;
            if (outq16 !== m_q || selq16 !== m_sel_q) begin
                bad++;
                $display("FAIL rnd_outq_%0d: got %h/%b expected %h/%b", i, outq16, selq16, m_q, m_sel_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_latency();
        test_enable_hold();
        test_async_reset();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux2
`default_nettype wire
